// File: rtl/video_rx_sync.sv
// ============================================================================
// Module   : video_rx_sync
// Purpose  : Sink-side video timing checker. Recovers pixel coordinates and
//            frame/line markers from HS/VS/BLANK/RGB and declares lock.
//            Optional checksum output: define VIDEO_RX_CHECKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module video_rx_sync #(
    parameter int HDISP       = 800,
    parameter int VDISP       = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                      pixel_clk,
    input  logic                      pixel_rst,
    input  logic                      vid_hs,
    input  logic                      vid_vs,
    input  logic                      vid_blank,
    input  logic [23:0]               vid_rgb,
    output logic                      pix_valid,
    output logic [$clog2(HDISP)-1:0]  pix_x,
    output logic [$clog2(VDISP)-1:0]  pix_y,
    output logic [23:0]               pix_rgb,
    output logic                      pix_sof,
    output logic                      pix_eol,
    output logic                      locked,
    output logic                      err_h,
    output logic                      err_v,
`ifdef VIDEO_RX_CHECKSUM_EN
    output logic [15:0]               frame_crc,
    output logic                      crc_valid,
`endif
    output logic [15:0]               frame_cnt
);

    localparam int c_XW  = $clog2(HDISP);
    localparam int c_YW  = $clog2(VDISP);
    localparam int c_HCW = $clog2(HDISP + 1);
    localparam int c_VCW = $clog2(VDISP + 1);
    localparam int c_GW  = $clog2(LOCK_FRAMES + 1);
    localparam logic [c_HCW-1:0] c_HMAX  = c_HCW'(HDISP);
    localparam logic [c_HCW-1:0] c_HLAST = c_HCW'(HDISP - 1);
    localparam logic [c_VCW-1:0] c_VMAX  = c_VCW'(VDISP);
    localparam logic [c_VCW-1:0] c_VLAST = c_VCW'(VDISP - 1);
    localparam logic [c_GW-1:0]  c_GLAST = c_GW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_GW-1:0]   r_good, w_good_nxt;

    logic              r_vs, r_vs_d, r_blank, r_blank_d;
    logic [23:0]       r_rgb;
    logic [c_HCW-1:0]  r_hcnt;
    logic              r_hovf;
    logic [c_VCW-1:0]  r_vcnt;
    logic              r_vovf;
    logic              r_herr_seen;

    logic              w_blank_rise, w_blank_fall, w_vs_fall;
    logic [c_HCW-1:0]  w_hidx, w_hidx_c;
    logic [c_VCW-1:0]  w_vcnt_c;
    logic              w_err_h, w_vcnt_bad, w_frame_bad, w_valid;

    // HS carries nothing the checker needs; line timing is taken from blank.
    logic              w_unused_hs;
    assign w_unused_hs = vid_hs;

    assign w_blank_rise = r_blank & ~r_blank_d;
    assign w_blank_fall = ~r_blank & r_blank_d;
    assign w_vs_fall    = ~r_vs & r_vs_d;

    assign w_hidx      = w_blank_rise ? '0 : r_hcnt;
    assign w_hidx_c    = (w_hidx > c_HLAST) ? c_HLAST : w_hidx;
    assign w_vcnt_c    = (r_vcnt > c_VLAST) ? c_VLAST : r_vcnt;
    assign w_err_h     = w_blank_fall & (r_hovf | (r_hcnt != c_HMAX));
    assign w_vcnt_bad  = r_vovf | (r_vcnt != c_VMAX);
    assign w_frame_bad = w_vcnt_bad | r_herr_seen | w_err_h;
    assign w_valid     = (r_state == S_LOCKED) & r_blank &
                         (w_hidx != c_HMAX) & (r_vcnt != c_VMAX);

    assign locked = (r_state == S_LOCKED);

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_vs        <= 1'b0;
            r_vs_d      <= 1'b0;
            r_blank     <= 1'b0;
            r_blank_d   <= 1'b0;
            r_rgb       <= '0;
            r_hcnt      <= '0;
            r_hovf      <= 1'b0;
            r_vcnt      <= '0;
            r_vovf      <= 1'b0;
            r_herr_seen <= 1'b0;
        end else begin
            r_vs      <= vid_vs;
            r_vs_d    <= r_vs;
            r_blank   <= vid_blank;
            r_blank_d <= r_blank;
            r_rgb     <= vid_rgb;
            // Saturate at HDISP; the overflow flag keeps long lines failing.
            if (r_blank) begin
                r_hovf <= (r_hovf & ~w_blank_rise) | (w_hidx == c_HMAX);
                if (w_hidx != c_HMAX)
                    r_hcnt <= w_hidx + 1'b1;
            end
            if (w_vs_fall) begin
                r_vcnt <= '0;
                r_vovf <= 1'b0;
            end else if (w_blank_fall && !w_err_h) begin
                if (r_vcnt == c_VMAX)
                    r_vovf <= 1'b1;
                else
                    r_vcnt <= r_vcnt + 1'b1;
            end
            if (w_vs_fall)
                r_herr_seen <= 1'b0;
            else if (w_err_h)
                r_herr_seen <= 1'b1;
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_state <= S_SEARCH;
            r_good  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        case (r_state)
            S_SEARCH: begin
                if (w_vs_fall) begin
                    w_state_nxt = S_SYNC;
                    w_good_nxt  = '0;
                end
            end
            S_SYNC: begin
                if (w_vs_fall) begin
                    if (w_frame_bad) begin
                        w_good_nxt = '0;
                    end else if (r_good == c_GLAST) begin
                        w_state_nxt = S_LOCKED;
                        w_good_nxt  = '0;
                    end else begin
                        w_good_nxt = r_good + 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (w_err_h || (w_vs_fall && w_frame_bad)) begin
                    w_state_nxt = S_SYNC;
                    w_good_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_SEARCH;
                w_good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            err_h     <= 1'b0;
            err_v     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            pix_valid <= w_valid;
            pix_x     <= w_hidx_c[c_XW-1:0];
            pix_y     <= w_vcnt_c[c_YW-1:0];
            if (w_valid)
                pix_rgb <= r_rgb;
            pix_sof   <= w_valid & (w_hidx == '0) & (r_vcnt == '0);
            pix_eol   <= w_valid & (w_hidx == c_HLAST);
            err_h     <= w_err_h;
            err_v     <= w_vs_fall & (r_state != S_SEARCH) & w_vcnt_bad;
            if (w_vs_fall && (r_state == S_LOCKED) && !w_frame_bad)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef VIDEO_RX_CHECKSUM_EN
    // CRC-16-CCITT, MSB first, bytes R then G then B.
    function automatic logic [15:0] f_crc24(input logic [15:0] crc, input logic [23:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ d[i])
                c = {c[14:0], 1'b0} ^ 16'h1021;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [15:0] r_crc;
    logic [15:0] w_crc_run;

    assign w_crc_run = w_valid ? f_crc24(r_crc, r_rgb) : r_crc;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_crc     <= 16'hFFFF;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (w_vs_fall) begin
                r_crc <= 16'hFFFF;
                if (r_state == S_LOCKED) begin
                    frame_crc <= w_crc_run;
                    crc_valid <= 1'b1;
                end
            end else begin
                r_crc <= w_crc_run;
            end
        end
    end
`else
    // Checksum disabled: no CRC state or ports.
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_rx_sync.sv
// ============================================================================
// Module   : tb_video_rx_sync
// Purpose  : Directed self-checking bench for video_rx_sync (20x6 frames).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_video_rx_sync;

    localparam int HD = 20;
    localparam int VD = 6;
    localparam int LF = 2;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst = 1'b1;
    logic        vid_hs    = 1'b1;
    logic        vid_vs    = 1'b1;
    logic        vid_blank = 1'b0;
    logic [23:0] vid_rgb   = '0;

    logic        pix_valid, pix_sof, pix_eol, locked, err_h, err_v;
    logic [4:0]  pix_x;
    logic [2:0]  pix_y;
    logic [23:0] pix_rgb;
    logic [15:0] frame_cnt;
`ifdef VIDEO_RX_CHECKSUM_EN
    logic [15:0] frame_crc;
    logic        crc_valid;
`endif

    video_rx_sync #(.HDISP(HD), .VDISP(VD), .LOCK_FRAMES(LF)) u_dut (
        .pixel_clk (pixel_clk),
        .pixel_rst (pixel_rst),
        .vid_hs    (vid_hs),
        .vid_vs    (vid_vs),
        .vid_blank (vid_blank),
        .vid_rgb   (vid_rgb),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_rgb   (pix_rgb),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .locked    (locked),
        .err_h     (err_h),
        .err_v     (err_v),
`ifdef VIDEO_RX_CHECKSUM_EN
        .frame_crc (frame_crc),
        .crc_valid (crc_valid),
`endif
        .frame_cnt (frame_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pat(input int x, input int y);
        return {8'(x * 3), 8'(y * 7 + 1), 8'(x ^ (y * 16) ^ 'h5A)};
    endfunction

    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int k = 0; k < 8; k++)
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    function automatic logic [15:0] crc_model();
        logic [15:0] c;
        logic [23:0] p;
        c = 16'hFFFF;
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++) begin
                p = pat(x, y);
                c = crc_byte(crc_byte(crc_byte(c, p[23:16]), p[15:8]), p[7:0]);
            end
        return c;
    endfunction

    // Monitor: sampled 1 ns after each rising edge.
    int          m_valid = 0, m_sof = 0, m_eol = 0, m_errh = 0, m_errv = 0;
    int          m_lock = 0, m_rgbbad = 0, m_maxx = 0, m_crcv = 0;
    logic        m_prev_locked = 1'b0, m_errh_prev_locked = 1'b0, m_errh_locked = 1'b1;
    logic [15:0] m_crc = '0;

    always @(posedge pixel_clk) begin
        #1;
        if (pix_valid) begin
            m_valid++;
            if (pix_rgb !== pat(int'(pix_x), int'(pix_y)))
                m_rgbbad++;
        end
        if (pix_sof) m_sof++;
        if (pix_eol) m_eol++;
        if (err_v)   m_errv++;
        if (locked)  m_lock++;
        if (err_h) begin
            m_errh++;
            m_errh_prev_locked = m_prev_locked;
            m_errh_locked      = locked;
        end
        if (int'(pix_x) > m_maxx) m_maxx = int'(pix_x);
        m_prev_locked = locked;
`ifdef VIDEO_RX_CHECKSUM_EN
        if (crc_valid) begin
            m_crcv++;
            m_crc = frame_crc;
        end
`endif
    end

    int d_valid, d_sof, d_eol, d_errh, d_errv, d_lock, d_rgbbad, d_crcv;

    task automatic cyc(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
        @(negedge pixel_clk);
        vid_hs    = hs;
        vid_vs    = vs;
        vid_blank = bl;
        vid_rgb   = rgb;
    endtask

    task automatic rst_pulse();
        check("pre_rst_locked", locked, 1);
        pixel_rst = 1'b1;
        #1;
        check("rst_valid", pix_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_rgb", pix_rgb, 0);
        check("rst_xy", {pix_x, pix_y}, 0);
        repeat (3) @(negedge pixel_clk);
        pixel_rst = 1'b0;
    endtask

    task automatic line(input int n_act, input int y, input logic vs, input int rst_at);
        for (int i = 0; i < n_act; i++) begin
            if (i == rst_at) rst_pulse();
            cyc(1'b1, vs, 1'b1, pat(i, y));
        end
        for (int i = 0; i < 6; i++)
            cyc((i == 2 || i == 3) ? 1'b0 : 1'b1, vs, 1'b0, 24'h0);
    endtask

    // One frame: active lines, then two blank lines, VS low during the first.
    task automatic frame(input int n_lines, input int bad_line, input int bad_len,
                         input int rst_line, input int rst_px);
        int s_valid, s_sof, s_eol, s_errh, s_errv, s_lock, s_rgbbad, s_crcv;
        s_valid = m_valid; s_sof = m_sof; s_eol = m_eol; s_errh = m_errh;
        s_errv = m_errv; s_lock = m_lock; s_rgbbad = m_rgbbad; s_crcv = m_crcv;
        for (int l = 0; l < n_lines; l++)
            line((l == bad_line) ? bad_len : HD, l, 1'b1, (l == rst_line) ? rst_px : -1);
        line(0, 0, 1'b0, -1);
        line(0, 0, 1'b1, -1);
        d_valid = m_valid - s_valid; d_sof = m_sof - s_sof; d_eol = m_eol - s_eol;
        d_errh = m_errh - s_errh; d_errv = m_errv - s_errv; d_lock = m_lock - s_lock;
        d_rgbbad = m_rgbbad - s_rgbbad; d_crcv = m_crcv - s_crcv;
    endtask

    initial begin
        repeat (3) @(negedge pixel_clk);
        check("reset_valid", pix_valid, 0);
        check("reset_locked", locked, 0);
        check("reset_errs", {err_h, err_v, pix_sof, pix_eol}, 0);
        check("reset_frame_cnt", frame_cnt, 0);
        pixel_rst = 1'b0;

        // Acquisition: SEARCH->SYNC, then two good frames.
        frame(VD, -1, 0, -1, 0);
        check("f1_locked", locked, 0);
        frame(VD, -1, 0, -1, 0);
        check("f2_locked", locked, 0);
        frame(VD, -1, 0, -1, 0);
        check("f3_locked", locked, 1);
        check("f3_frame_cnt", frame_cnt, 0);
        check("f1_3_errs", m_errh + m_errv, 0);

        frame(VD, -1, 0, -1, 0);
        check("f4_valid", d_valid, HD * VD);
        check("f4_sof", d_sof, 1);
        check("f4_eol", d_eol, VD);
        check("f4_rgb", d_rgbbad, 0);
        check("f4_frame_cnt", frame_cnt, 1);
        check("f4_rgb_hold", pix_rgb, pat(HD - 1, VD - 1));
`ifdef VIDEO_RX_CHECKSUM_EN
        check("f4_crc_pulse", d_crcv, 1);
        check("f4_crc", m_crc, crc_model());
`endif
        frame(VD, -1, 0, -1, 0);
        check("f5_frame_cnt", frame_cnt, 2);
        check("f5_errs", d_errh + d_errv, 0);
`ifdef VIDEO_RX_CHECKSUM_EN
        check("f5_crc", m_crc, crc_model());
`endif

        // Short line (19 px) on line 3 while locked.
        frame(VD, 3, HD - 1, -1, 0);
        check("short_errh", d_errh, 1);
        check("short_prev_locked", m_errh_prev_locked, 1);
        check("short_locked_drop", m_errh_locked, 0);
        check("short_valid", d_valid, 3 * HD + HD - 1);
        check("short_eol", d_eol, 3);
        check("short_errv", d_errv, 1);
        check("short_frame_cnt", frame_cnt, 2);
        frame(VD, -1, 0, -1, 0);
        check("short_r1_locked", locked, 0);
`ifdef VIDEO_RX_CHECKSUM_EN
        check("sync_crc_pulse", d_crcv, 0);
`endif
        frame(VD, -1, 0, -1, 0);
        check("short_r2_locked", locked, 1);
        frame(VD, -1, 0, -1, 0);
        check("relock_valid", d_valid, HD * VD);
        check("relock_frame_cnt", frame_cnt, 3);

        // Long line (21 px) on line 2 while locked.
        frame(VD, 2, HD + 1, -1, 0);
        check("long_errh", d_errh, 1);
        check("long_valid", d_valid, 2 * HD + HD);
        check("long_eol", d_eol, 3);
        check("long_max_x", m_maxx, HD - 1);
        check("long_locked", locked, 0);
        check("long_rgb", d_rgbbad, 0);
        frame(VD, -1, 0, -1, 0);
        frame(VD, -1, 0, -1, 0);
        check("long_relock", locked, 1);
        frame(VD, -1, 0, -1, 0);
        check("pre_rst_frame_cnt", frame_cnt, 4);

        // Reset mid-line (line 2, pixel 5) while locked.
        frame(VD, -1, 0, 2, 5);
        check("post_rst_locked", locked, 0);
        check("post_rst_frame_cnt", frame_cnt, 0);
        frame(VD, -1, 0, -1, 0);
        check("post_rst_f2_locked", locked, 0);
        frame(VD, -1, 0, -1, 0);
        check("post_rst_f3_locked", locked, 1);
        frame(VD, -1, 0, -1, 0);
        check("post_rst_valid", d_valid, HD * VD);
        check("post_rst_cnt", frame_cnt, 1);

        // Frames one line short: each ends with err_v, lock never returns.
        frame(VD - 1, -1, 0, -1, 0);
        check("vshort_errv", d_errv, 1);
        check("vshort_errh", d_errh, 0);
        check("vshort_locked", locked, 0);
        check("vshort_frame_cnt", frame_cnt, 1);
        frame(VD - 1, -1, 0, -1, 0);
        check("vshort2_errv", d_errv, 1);
        check("vshort2_lock", d_lock, 0);
        frame(VD - 1, -1, 0, -1, 0);
        check("vshort3_errv", d_errv, 1);
        check("vshort3_lock", d_lock, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/video_rx_sync.md
Name: video_rx_sync

Overview:
- Sink-side counterpart of the VGA controller's video_if master output.
- Samples HS/VS/BLANK/RGB on the pixel clock and recovers pixel coordinates and frame/line markers.
- Checks timing against the expected HDISP/VDISP and declares lock.
- Used as an in-fabric loopback checker and as the front end of a future capture path feeding SDRAM via hws_if.

Parameters:
HDISP, 800, active pixels per line expected
VDISP, 480, active lines per frame expected
LOCK_FRAMES, 2, consecutive conforming frames required before locked asserts

Ports:
pixel_clk  input  1  pixel clock; all logic on rising edge
pixel_rst  input  1  asynchronous active-high reset
vid_hs  input  1  horizontal sync, active low
vid_vs  input  1  vertical sync, active low
vid_blank  input  1  1 = active pixel, 0 = blanking
vid_rgb  input  24  pixel colour {R,G,B}
pix_valid  output  1  recovered active pixel, only while locked
pix_x  output  $clog2(HDISP)  column of current pixel
pix_y  output  $clog2(VDISP)  row of current pixel
pix_rgb  output  24  registered colour
pix_sof  output  1  with pix_valid at x=0,y=0
pix_eol  output  1  with pix_valid at x=HDISP-1
locked  output  1  timing conforms
err_h  output  1  one-cycle pulse: line length mismatch
err_v  output  1  one-cycle pulse: line count mismatch
frame_cnt  output  16  frames received while locked, wraps

Behaviour:
- Reset (async, immediate): all outputs 0, counters 0, state SEARCH.
- Inputs registered once (stage s1). Edges detected between s1 and previous s1.
- All pix_* outputs are registered from s1: latency 2 cycles from the input pin to pix_*.
- hcnt counts the active run: it clears on the rising edge of blank and increments while blank=1.
- On the falling edge of blank:
  - If hcnt != HDISP, pulse err_h.
  - Otherwise increment vcnt.
- vcnt clears on the falling edge of vs.
- On the falling edge of vs, evaluate the previous frame: it fails if vcnt != VDISP or any err_h occurred during it.
  - In SYNC/LOCKED, a vcnt mismatch pulses err_v.
  - err_h and err_v can pulse in the same cycle.
- FSM:
  - SEARCH -> SYNC on the first vs falling edge. good=0.
  - SYNC: on each vs falling edge, a conforming frame increments good. When good reaches LOCK_FRAMES: locked=1, go to LOCKED. A non-conforming frame resets good to 0 and stays in SYNC.
  - LOCKED: err_h, or a non-conforming frame, drops locked immediately (next cycle) and goes to SYNC with good=0.
  - LOCKED: frame_cnt increments on each conforming vs falling edge.
- pix_valid = (state==LOCKED) and s1 blank=1 and hcnt<HDISP and vcnt<VDISP.
- pix_x = hcnt, pix_y = vcnt.
- Pixels beyond HDISP within a line: no pix_valid; the line is flagged err_h at its end. The x counter saturates at HDISP and does not wrap.
- Lines beyond VDISP: no pix_valid; the vcnt counter saturates at VDISP.
- blank=1 during vs low is legal and counted normally.
- Reset mid-frame: the next vs falling edge is treated as the first.
- frame_cnt wraps 0xFFFF -> 0.
- pix_rgb holds its last value when pix_valid=0.

Optional Feature:
VIDEO_RX_CHECKSUM_EN
- Defined:
  - Adds output frame_crc (16 bits): CRC-16-CCITT (poly 0x1021, init 0xFFFF) over pix_rgb bytes R,G,B of every pix_valid pixel.
  - Adds crc_valid: a one-cycle pulse on the vs falling edge that ends a frame evaluated in LOCKED.
  - frame_crc holds until the next pulse. The CRC is reset at the start of each frame.
- Undefined: no ports or logic for the checksum are generated.

Test Plan:
- 160x90 conforming frames from the VGA controller, LOCK_FRAMES=2 -> locked=1 after the 3rd vs falling edge (SEARCH->SYNC, then 2 good frames). From frame 4: 14400 pix_valid per frame, one pix_sof, 90 pix_eol, frame_cnt increments by 1 per frame.
- In LOCKED, one line shortened to 159 active pixels -> single err_h pulse at that line's blank fall, locked=0 the next cycle, relock after 2 further good frames.
- Frame with 89 active lines -> err_v pulse at the following vs fall, locked never asserts while every frame has 89 lines.
- Line of 161 pixels while locked -> pix_x never exceeds 159, no pix_valid for the 161st pixel, err_h pulses.
- Assert pixel_rst mid-line while locked -> all outputs 0 asynchronously. After release, state is SEARCH and locked reasserts only after 1+LOCK_FRAMES vs edges.
- With VIDEO_RX_CHECKSUM_EN: constant RGB 0x000000 for 160x90 -> crc_valid pulses once per locked frame with an identical frame_crc each frame. Changing one pixel to 0x0000FF alters frame_crc.
